bcd_store_seq: RTL and testbench
================================

Name: bcd_store_seq

Overview:
- Sequencer for the Chip-8 FX33 instruction: converts an 8-bit register value to three BCD digits and writes them as bytes to memory at I, I+1, I+2.
- Sits between the CPU execute stage, which issues start, and the main memory write port.
- Owns the memory write port for the duration of the operation; the CPU waits on done.

Parameters:
- ADDR_W, 12, memory address width (Chip-8 4 KB space); address arithmetic wraps modulo 2^ADDR_W.
- GAP_CYCLES, 0, idle cycles inserted between consecutive byte writes (0..3).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- value  in  8  register Vx value; sampled on the accepted start.
- base_addr  in  ADDR_W  index register I; sampled on the accepted start.
- mem_stall  in  1  memory not ready; the current write is held until this is low.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data; upper nibble always 0.
- mem_we  out  1  write enable; a byte commits on a cycle with mem_we=1 and mem_stall=0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the third byte has committed.

Behaviour:
- Reset (async): state=IDLE; mem_we=0, done=0, busy=0, mem_addr=0, mem_wdata=0. Takes effect immediately, including mid-operation. No further writes are issued. A partially written digit triple is left as-is.
- States: IDLE, WR_H, WR_T, WR_O, GAP, FIN.
- IDLE -> WR_H on start.
  - On that edge, latch the hundreds, tens and ones digits, computed combinationally from value.
  - On that edge, latch addr_q = base_addr.
- WR_H drives mem_we=1, mem_addr=addr_q, mem_wdata={4'h0,hundreds}.
- WR_T drives mem_we=1, mem_addr=addr_q+1, mem_wdata={4'h0,tens}.
- WR_O drives mem_we=1, mem_addr=addr_q+2, mem_wdata={4'h0,ones}.
- Advance from a write state only on a cycle where mem_stall=0. While mem_stall=1, hold the state and hold all outputs stable.
- Write-state successors:
  - WR_H and WR_T go to the next write state when GAP_CYCLES=0.
  - Otherwise they go to GAP for GAP_CYCLES cycles, with mem_we=0 and a gap counter; GAP then goes to the next write state.
- WR_O -> FIN. FIN drives done=1 for exactly one cycle and returns to IDLE.
- Latency (GAP_CYCLES=0, no stall):
  - start accepted at edge 0.
  - Writes occur in cycles 1, 2, 3.
  - done is high in cycle 4; busy is high in cycles 1-4.
- Total cycles = 4 + 2*GAP_CYCLES + number of stall cycles.
- Address addition is modulo 2^ADDR_W: base 0xFFF gives addresses 0xFFF, 0x000, 0x001.
- start while busy=1 is ignored; there is no queueing. start in the FIN cycle is also ignored.
- Changes to value or base_addr after acceptance have no effect.
- Digits always satisfy hundreds<=2, tens<=9, ones<=9 for all 256 inputs.
- mem_wdata and mem_addr are don't-care when mem_we=0, but are driven to 0 in IDLE.
- Outputs are registered (Moore); there is no combinational path from mem_stall to any output.

Decomposition:
- Shared package chip8_pkg holds:
  - typedef state_t (enum for the six states);
  - localparam CHIP8_ADDR_W = 12;
  - typedef addr_t = logic [CHIP8_ADDR_W-1:0].
- One sub-module: bcd, the existing 8-bit double-dabble converter (num -> hundreds/tens/ones), instantiated on value. Its outputs are latched on start.
- Everything else (FSM, gap counter, address adder) is inline.

Test Plan:
- value=0xFF, base_addr=0x300, no stall -> writes (0x300,0x02), (0x301,0x05), (0x302,0x05) in cycles 1-3; done in cycle 4; busy is 0 in cycle 5.
- value=0x00, base_addr=0xFFE -> writes (0xFFE,0x00), (0xFFF,0x00), (0x000,0x00); this checks address wrap.
- value=0x7B (123), mem_stall=1 for 2 cycles during WR_T:
  - addr 0x201 and data 0x02 are held stable while stalled;
  - total latency is 6 cycles;
  - exactly three committed writes: 0x01, 0x02, 0x03.
- start pulsed again in cycles 2 and 4 during an op with value=9 -> ignored; only the bytes 0,0,9 are written and exactly one done pulse occurs.
- reset asserted asynchronously mid-cycle during WR_T -> mem_we and busy drop before the next edge; state=IDLE; no WR_O write; a subsequent start runs normally.
- Exhaustive sweep of value 0..255 with random base_addr and random stalls:
  - committed bytes equal value/100, (value/10)%10, value%10;
  - GAP_CYCLES=2 variant checks the gap cycles have mem_we=0 and total latency is 8.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared Chip-8 definitions: address width, address type and the
// FX33 (BCD store) sequencer state encoding.
package chip8_pkg;

  localparam int CHIP8_ADDR_W = 12;

  typedef logic [CHIP8_ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_H,
    ST_WR_T,
    ST_WR_O,
    ST_GAP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/bcd_store_seq_bcd.sv
// bcd: combinational 8-bit binary to three-digit BCD converter (double dabble).
// Ports:
//   num      - binary input 0..255
//   hundreds - hundreds digit (0..2)
//   tens     - tens digit (0..9)
//   ones     - ones digit (0..9)
module bcd (
  input  logic [7:0] num,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // {hundreds, tens, ones, binary} scratch register shifted left 8 times
  logic [19:0] w_shift;

  always_comb begin
    w_shift = {12'b0, num};
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_shift[11:8]  >= 4'd5) w_shift[11:8]  = w_shift[11:8]  + 4'd3;
      if (w_shift[15:12] >= 4'd5) w_shift[15:12] = w_shift[15:12] + 4'd3;
      if (w_shift[19:16] >= 4'd5) w_shift[19:16] = w_shift[19:16] + 4'd3;
      w_shift = w_shift << 1;
    end
    hundreds = w_shift[19:16];
    tens     = w_shift[15:12];
    ones     = w_shift[11:8];
  end

endmodule

// File: rtl/bcd_store_seq.sv
// bcd_store_seq: Chip-8 FX33 sequencer. On an accepted start it latches the
// BCD digits of value and base_addr, then writes hundreds, tens and ones to
// base, base+1, base+2 (wrapping), optionally separated by idle gap cycles,
// and pulses done once the third byte has committed.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   start                - one-cycle request, honoured only in IDLE
//   value, base_addr     - operands, sampled on the accepted start
//   mem_stall            - memory not ready; current write is held
//   mem_addr, mem_wdata  - write address / data (upper nibble 0)
//   mem_we               - write enable; commit when mem_we && !mem_stall
//   busy                 - high in every state except IDLE
//   done                 - one-cycle completion pulse
module bcd_store_seq
  import chip8_pkg::*;
#(
  parameter int ADDR_W     = CHIP8_ADDR_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        value,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  // GAP counts down from GAP_CYCLES-1 to 0, giving GAP_CYCLES idle cycles
  localparam logic [1:0] GAP_LOAD = 2'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  state_t            r_gap_ret;
  state_t            w_gap_ret_nxt;
  logic [1:0]        r_gap;
  logic [1:0]        w_gap_nxt;
  logic [3:0]        r_hund;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        w_hund;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;

  bcd u_bcd (
    .num      (value),
    .hundreds (w_hund),
    .tens     (w_tens),
    .ones     (w_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gap_ret <= ST_WR_T;
      r_gap     <= '0;
      r_hund    <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_next;
      r_gap_ret <= w_gap_ret_nxt;
      r_gap     <= w_gap_nxt;
      if (r_state == ST_IDLE && start) begin
        r_hund <= w_hund;
        r_tens <= w_tens;
        r_ones <= w_ones;
        r_addr <= base_addr;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_gap_nxt     = r_gap;
    w_gap_ret_nxt = r_gap_ret;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_WR_H;
      ST_WR_H: begin
        if (!mem_stall) begin
          if (GAP_CYCLES == 0) begin
            w_next = ST_WR_T;
          end else begin
            w_next        = ST_GAP;
            w_gap_nxt     = GAP_LOAD;
            w_gap_ret_nxt = ST_WR_T;
          end
        end
      end
      ST_WR_T: begin
        if (!mem_stall) begin
          if (GAP_CYCLES == 0) begin
            w_next = ST_WR_O;
          end else begin
            w_next        = ST_GAP;
            w_gap_nxt     = GAP_LOAD;
            w_gap_ret_nxt = ST_WR_O;
          end
        end
      end
      ST_WR_O: if (!mem_stall) w_next = ST_FIN;
      ST_GAP: begin
        if (r_gap == 2'd0) w_next = r_gap_ret;
        else               w_gap_nxt = r_gap - 2'd1;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decode only registered state, so mem_stall never reaches them
  // combinationally and a stall naturally freezes them.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_FIN);
    case (r_state)
      ST_WR_H: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = {4'h0, r_hund};
      end
      ST_WR_T: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr + ADDR_W'(1);
        mem_wdata = {4'h0, r_tens};
      end
      ST_WR_O: begin
        mem_we    = 1'b1;
        mem_addr  = r_addr + ADDR_W'(2);
        mem_wdata = {4'h0, r_ones};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_store_seq.sv
module tb_bcd_store_seq;
  import chip8_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start2;
  logic [7:0] value;
  addr_t      base_addr;
  logic       mem_stall;

  addr_t      addr0, addr2;
  logic [7:0] wdata0, wdata2;
  logic       we0, we2, busy0, busy2, done0, done2;

  logic       sel;
  addr_t      o_addr;
  logic [7:0] o_wdata;
  logic       o_we, o_busy, o_done;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_check = 0;

  always #5 clk = ~clk;

  bcd_store_seq #(.ADDR_W(CHIP8_ADDR_W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .value(value),
    .base_addr(base_addr), .mem_stall(mem_stall), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_we(we0), .busy(busy0), .done(done0)
  );

  bcd_store_seq #(.ADDR_W(CHIP8_ADDR_W), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .value(value),
    .base_addr(base_addr), .mem_stall(mem_stall), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_we(we2), .busy(busy2), .done(done2)
  );

  always_comb begin
    o_addr  = sel ? addr2  : addr0;
    o_wdata = sel ? wdata2 : wdata0;
    o_we    = sel ? we2    : we0;
    o_busy  = sel ? busy2  : busy0;
    o_done  = sel ? done2  : done0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // stall_mode: 0 none, 1 random, 2 stall_n cycles on write index stall_k
  task automatic run_op(input logic s, input logic [7:0] v, input addr_t b,
                        input int stall_mode, input int stall_k, input int stall_n,
                        input bit extra_start);
    int         g;
    int         nstall, ncommit, done_cyc, gap_cyc, forced;
    logic [3:0] dig [3];
    g        = s ? 2 : 0;
    nstall   = 0;
    ncommit  = 0;
    done_cyc = -1;
    gap_cyc  = 0;
    forced   = 0;
    dig[0]   = 4'(v / 100);
    dig[1]   = 4'((v / 10) % 10);
    dig[2]   = 4'(v % 10);

    @(negedge clk);
    sel = s; value = v; base_addr = b; mem_stall = 1'b0;
    if (s) start2 = 1'b1; else start0 = 1'b1;

    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      value = 8'($urandom); base_addr = addr_t'($urandom);
      if (extra_start && (cyc == 2 || cyc == 4)) begin
        if (s) start2 = 1'b1; else start0 = 1'b1;
      end
      check("busy_in_op", o_busy, 1);
      if (o_we) begin
        case (stall_mode)
          1:       mem_stall = ($urandom_range(0, 2) == 0);
          2:       mem_stall = (ncommit == stall_k) && (forced < stall_n);
          default: mem_stall = 1'b0;
        endcase
        if (mem_stall) forced++;
        if (ncommit < 3) begin
          check("wr_addr", o_addr, addr_t'(b + addr_t'(ncommit)));
          check("wr_data", o_wdata, {4'h0, dig[ncommit]});
        end else begin
          check("write_overrun", ncommit, 2);
        end
        if (mem_stall) nstall++; else ncommit++;
      end else begin
        mem_stall = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!o_done) gap_cyc++;
      end
      if (o_done) done_cyc = cyc;
    end

    check("done_latency", done_cyc, 4 + 2 * g + nstall);
    check("commits", ncommit, 3);
    check("gap_idle_cycles", gap_cyc, 2 * g);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0; mem_stall = 1'b0;
      check("post_busy", o_busy, 0);
      check("post_done", o_done, 0);
      check("post_we", o_we, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start2 = 1'b0; mem_stall = 1'b0;
    value = '0; base_addr = '0; sel = 1'b0;
    #12;
    check("rst_we", {we0, we2}, 0);
    check("rst_busy", {busy0, busy2}, 0);
    check("rst_done", {done0, done2}, 0);
    check("rst_addr", {addr0, addr2}, 0);
    check("rst_wdata", {wdata0, wdata2}, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 8'hFF, 12'h300, 0, 0, 0, 1'b0);
    run_op(1'b0, 8'h00, 12'hFFE, 0, 0, 0, 1'b0);
    run_op(1'b0, 8'h7B, 12'h200, 2, 1, 2, 1'b0);
    run_op(1'b0, 8'd9, addr_t'($urandom), 0, 0, 0, 1'b1);
    run_op(1'b0, 8'h42, 12'hFFF, 0, 0, 0, 1'b0);

    // asynchronous reset in the middle of the tens write
    @(negedge clk);
    sel = 1'b0; value = 8'd77; base_addr = 12'h123; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check("pre_rst_we", o_we, 1);
    check("pre_rst_addr", o_addr, 12'h124);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", o_we, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_addr", o_addr, 0);
    check("mid_rst_wdata", o_wdata, 0);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("after_rst_we", o_we, 0);
      check("after_rst_busy", o_busy, 0);
    end
    run_op(1'b0, 8'd77, 12'h123, 0, 0, 0, 1'b0);

    for (int v = 0; v < 256; v++)
      run_op(1'b0, 8'(v), addr_t'($urandom), 1, 0, 0, 1'b0);

    run_op(1'b1, 8'hFF, 12'h300, 0, 0, 0, 1'b0);
    run_op(1'b1, 8'h7B, 12'hFFF, 2, 1, 2, 1'b0);
    for (int v = 0; v < 256; v++)
      run_op(1'b1, 8'(v), addr_t'($urandom), 1, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
